// File: rtl/mod_down_counter_pkg.sv
// mod_down_counter_pkg: state encoding and load-value clamp for the modulo-N down counter.
package mod_down_counter_pkg;
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;
  function automatic int unsigned clamp_val(input int unsigned val, input int unsigned modulus);
    return (val >= modulus) ? modulus - 1 : val;
  endfunction
endpackage

// File: rtl/mod_down_counter_reg.sv
// counter_reg: WIDTH-bit register with synchronous active-high reset and load enable.
module counter_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk)
    if (rst) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/mod_down_counter.sv
// mod_down_counter: loadable modulo-N down counter with terminal-count pulse and auto-reload.
// Define MOD_DOWN_COUNTER_UPDOWN_EN to add the 'up' port for up/down counting.
module mod_down_counter
  import mod_down_counter_pkg::*;
#(
  parameter int MODULUS = 5,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  state_t           r_state, w_state_d;
  logic             r_tc, w_tc_d, w_q_en, w_up, w_at_end;
  logic [WIDTH-1:0] w_q, w_q_d, w_load_q;
`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
  assign w_up = up;
`else
  assign w_up = 1'b0;
`endif
  assign w_load_q = WIDTH'(clamp_val(32'(load_val), MODULUS));
  assign w_at_end = w_up ? (w_q == MAX) : (w_q == '0);
  counter_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_q_en),
    .i_d  (w_q_d),
    .o_q  (w_q)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_tc    <= w_tc_d;
    end
  // Terminal step either reloads to the opposite end or parks at the current end and idles.
  always_comb begin
    w_state_d = r_state;
    w_tc_d    = 1'b0;
    w_q_en    = 1'b0;
    w_q_d     = w_q;
    if (load) begin
      w_state_d = COUNT;
      w_q_en    = 1'b1;
      w_q_d     = w_load_q;
    end else if (r_state == COUNT && en) begin
      w_q_en = 1'b1;
      w_tc_d = w_at_end;
      w_q_d  = !w_at_end ? (w_up ? w_q + 1'b1 : w_q - 1'b1) :
               auto_reload ? (w_up ? '0 : MAX) : w_q;
      w_state_d = (w_at_end && !auto_reload) ? IDLE : COUNT;
    end
  end
  always_comb begin
    busy = (r_state == COUNT);
    tc   = r_tc;
    q    = w_q;
  end
endmodule

// File: tb/tb_mod_down_counter.sv
// tb_mod_down_counter: directed self-checking bench for mod_down_counter (MODULUS=5, WIDTH=3).
module tb_mod_down_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;
  logic       auto_reload = 1'b0;
`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
  logic       up = 1'b0;
`endif
  logic [2:0] q;
  logic       tc, busy;
  int checks = 0;
  int errors = 0;

  mod_down_counter #(.MODULUS(5), .WIDTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
    .up          (up),
`endif
    .q           (q),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] eq, input logic etc, input logic ebusy);
    checks++;
    if (q !== eq || tc !== etc || busy !== ebusy) begin
      errors++;
      $display("FAIL %s: got q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=%b", name, q, tc, busy, eq, etc, ebusy);
    end
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_out("reset", 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    expect_out("idle_en_1", 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("idle_en_2", 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_one_shot();
    auto_reload = 1'b0;
    en = 1'b1;
    do_load(3'd4);
    expect_out("oneshot_load", 3'd4, 1'b0, 1'b1);
    tick(); expect_out("oneshot_3", 3'd3, 1'b0, 1'b1);
    tick(); expect_out("oneshot_2", 3'd2, 1'b0, 1'b1);
    tick(); expect_out("oneshot_1", 3'd1, 1'b0, 1'b1);
    tick(); expect_out("oneshot_0", 3'd0, 1'b0, 1'b1);
    tick(); expect_out("oneshot_tc", 3'd0, 1'b1, 1'b0);
    tick(); expect_out("oneshot_hold", 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_auto_reload();
    logic [2:0] exp_q [15] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
    logic       exp_t [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int pulses = 0;
    auto_reload = 1'b1;
    en = 1'b1;
    do_load(3'd7);
    expect_out("clamp_7", 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tc === 1'b1) pulses++;
      expect_out($sformatf("reload_%0d", i), exp_q[i], exp_t[i], 1'b1);
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL reload_pulses: got %0d, want 3", pulses);
    end
  endtask

  task automatic test_pause();
    auto_reload = 1'b0;
    en = 1'b1;
    do_load(3'd4);
    tick();
    tick();
    expect_out("pause_at_2", 3'd2, 1'b0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("pause_hold_%0d", i), 3'd2, 1'b0, 1'b1);
    end
    en = 1'b1;
    tick(); expect_out("resume_1", 3'd1, 1'b0, 1'b1);
    tick(); expect_out("resume_0", 3'd0, 1'b0, 1'b1);
    tick(); expect_out("resume_tc", 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_load_priority();
    auto_reload = 1'b0;
    en = 1'b1;
    do_load(3'd1);
    tick();
    expect_out("prio_at_0", 3'd0, 1'b0, 1'b1);
    do_load(3'd3);
    expect_out("prio_load_wins", 3'd3, 1'b0, 1'b1);
    tick();
    expect_out("prio_count", 3'd2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mid_reset", 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_load_zero();
    auto_reload = 1'b0;
    en = 1'b1;
    do_load(3'd0);
    expect_out("zero_load", 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("zero_tc", 3'd0, 1'b1, 1'b0);
    tick();
    expect_out("zero_after", 3'd0, 1'b0, 1'b0);
  endtask

`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
  task automatic test_updown();
    auto_reload = 1'b1;
    en = 1'b1;
    up = 1'b1;
    do_load(3'd3);
    expect_out("up_load", 3'd3, 1'b0, 1'b1);
    tick(); expect_out("up_4", 3'd4, 1'b0, 1'b1);
    tick(); expect_out("up_wrap", 3'd0, 1'b1, 1'b1);
    up = 1'b0;
    tick(); expect_out("down_wrap", 3'd4, 1'b1, 1'b1);
    tick(); expect_out("down_3", 3'd3, 1'b0, 1'b1);
    up = 1'b1;
    auto_reload = 1'b0;
    tick(); expect_out("up_stop_4", 3'd4, 1'b0, 1'b1);
    tick(); expect_out("up_stop_tc", 3'd4, 1'b1, 1'b0);
    up = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause();
    test_load_priority();
    test_load_zero();
`ifdef MOD_DOWN_COUNTER_UPDOWN_EN
    test_updown();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
